rr_line_arbiter: RTL and testbench
==================================

# rr_line_arbiter

Round-robin arbiter that shares one 3-to-8 enabled line decoder among 8 requesters. It grants one requester at a time and drives the decoder's Enable and 3-bit select from registered state. It also produces the decoded one-hot grant internally, so requesters can use it directly. A programmable hold limit stops any single requester from keeping the resource indefinitely.

## Interface
- MAX_HOLD, 15: maximum consecutive grant cycles per ownership. 0 disables the timeout. Legal range 0..255.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  8  request lines; req[i] high means requester i wants the resource.
- release  input  1  current owner gives up the grant; sampled only in GRANT.
- grant_en  output  1  decoder Enable; high while a requester owns the resource.
- grant_idx  output  3  decoder select {A,B,C}, A is MSB; index of the current owner.
- grant  output  8  one-hot decode: grant[grant_idx]=grant_en, all other bits 0.
- timeout  output  1  one-cycle pulse when an ownership ends by hold limit.
- busy  output  1  high in GRANT and HOLDOFF.

## Operation
- Reset (synchronous, active-high): state=IDLE, ptr=0, grant_en=0, grant_idx=0, grant=0, timeout=0, busy=0, hold_cnt=0.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first i with req[i]=1, searching cyclically ptr, ptr+1, …, 7, 0, …, ptr-1.
  - Load grant_idx=i, set grant_en=1, hold_cnt=1, go to GRANT.
- State GRANT: stay while req[grant_idx]=1, release=0, and the hold limit is not reached. Exit to HOLDOFF on the first of:
  - release=1;
  - req[grant_idx]=0 (requester withdrew);
  - MAX_HOLD≠0 and hold_cnt==MAX_HOLD (timeout).
- On any exit from GRANT:
  - grant_en=0 and grant=0;
  - ptr=grant_idx+1 mod 8, so 7 wraps to 0;
  - grant_idx keeps its last value.
- State HOLDOFF: one cycle with grant_en=0, then unconditionally IDLE. It guarantees a dead cycle between owners on the shared decoder.
- hold_cnt:
  - 8 bits wide; increments each cycle in GRANT while staying;
  - saturates at 255 when MAX_HOLD=0;
  - cleared in IDLE.
- timeout: asserted in the HOLDOFF cycle that follows a timeout exit; 0 otherwise.
- Simultaneous exit conditions: release or withdrawal takes priority over timeout. If release/withdrawal and the hold limit coincide, timeout stays 0.
- A requester that drops req while not granted is not remembered; no queueing.
- Changes to req in HOLDOFF are ignored; req is evaluated only in IDLE.

## Timing
- All outputs are registered; nothing is combinational from req or release to any output.
- Grant latency: req[i] high before edge k with the arbiter in IDLE → grant_en=1, grant_idx=i, grant[i]=1 after edge k.
- Release: release=1 sampled at edge m in GRANT → grant_en=0 after edge m, IDLE after edge m+1, next grant earliest after edge m+2.
- Owner-to-owner gap: exactly 2 cycles with grant_en=0 (HOLDOFF + IDLE arbitration).
- Timeout: with MAX_HOLD=N, grant_en is high exactly N consecutive cycles. timeout=1 for the one cycle after grant_en falls.
- Reset mid-grant: reset sampled at edge r → all outputs at reset values after edge r. ptr returns to 0.

## Test plan
- Reset then single request: reset 2 cycles; req=8'b0010_0000, release=0, held 3 cycles, then release=1 for one cycle.
  - grant_idx=5 and grant=8'b0010_0000 one cycle after req.
  - grant_en falls one cycle after release.
  - busy=1 during GRANT and HOLDOFF.
- Round-robin fairness: req=8'hFF held, release pulsed one cycle after each grant.
  - Grant order 0,1,2,…,7,0 (wrap).
  - Exactly 2 idle cycles between grants.
- Priority rotation from the pointer: after owner 6 releases, req=8'b0100_0101.
  - Next grant is 0 (search order 7, 0, …).
  - The following grant is 2.
- Timeout: MAX_HOLD=4, req=8'b0000_1000 held, release=0.
  - grant_en high exactly 4 cycles; timeout=1 for one cycle.
  - Requester 3 is regranted 2 cycles after grant_en falls.
- Release coinciding with timeout: MAX_HOLD=4, release=1 in the 4th grant cycle → timeout stays 0. Separately, withdrawing req mid-grant → grant_en falls one cycle later.
- Reset mid-grant: assert reset while owner 2 holds.
  - All outputs 0 next cycle.
  - With req=8'b0000_0110 afterwards, first grant is 1 (ptr=0).

Source files
------------

// File: rtl/rr_line_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 enabled line decoder among 8 requesters.
// Drives the decoder Enable/select and a one-hot grant, all from registered state.
module rr_line_arbiter #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       release_req,
  output logic       grant_en,
  output logic [2:0] grant_idx,
  output logic [7:0] grant,
  output logic       timeout,
  output logic       busy
);

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic             HOLD_ON  = (MAX_HOLD != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_HOLDOFF
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               grant_en_q, grant_en_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               timeout_q, timeout_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic               owner_drop;
  logic               hold_hit;

  // Cyclic search for the first requester starting at the pointer.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = ptr_q + IDX_W'(k);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Release/withdrawal outranks the hold limit when both occur together.
  assign owner_drop = release_req || !req[grant_idx_q];
  assign hold_hit   = HOLD_ON && (hold_cnt_q == HOLD_LIM);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_en_d  = grant_en_q;
    grant_idx_d = grant_idx_q;
    grant_d     = grant_q;
    timeout_d   = 1'b0;
    busy_d      = busy_q;
    hold_cnt_d  = hold_cnt_q;

    case (state_q)
      ST_IDLE: begin
        hold_cnt_d = '0;
        if (pick_vld) begin
          state_d     = ST_GRANT;
          grant_en_d  = 1'b1;
          grant_idx_d = pick_idx;
          grant_d     = N_REQ'(1) << pick_idx;
          hold_cnt_d  = CNT_W'(1);
          busy_d      = 1'b1;
        end
      end
      ST_GRANT: begin
        if (owner_drop || hold_hit) begin
          state_d    = ST_HOLDOFF;
          grant_en_d = 1'b0;
          grant_d    = '0;
          ptr_d      = grant_idx_q + IDX_W'(1);
          timeout_d  = !owner_drop;
          busy_d     = 1'b1;
        end else if (hold_cnt_q != CNT_MAX) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      ST_HOLDOFF: begin
        // Dead cycle on the shared decoder between owners.
        state_d    = ST_IDLE;
        busy_d     = 1'b0;
        hold_cnt_d = '0;
      end
      default: begin
        state_d    = ST_IDLE;
        grant_en_d = 1'b0;
        grant_d    = '0;
        busy_d     = 1'b0;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_en_q  <= 1'b0;
      grant_idx_q <= '0;
      grant_q     <= '0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_en_q  <= grant_en_d;
      grant_idx_q <= grant_idx_d;
      grant_q     <= grant_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign grant_en  = grant_en_q;
  assign grant_idx = grant_idx_q;
  assign grant     = grant_q;
  assign timeout   = timeout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rr_line_arbiter.sv
// Self-checking bench for rr_line_arbiter: directed vector table, hand-written
// multi-cycle sequences, and random traffic against an ownership-level model.
module tb_rr_line_arbiter;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       r_rst = 1'b1;
  logic [7:0] r_req = 8'h00;
  logic       r_rel = 1'b0;
  logic       grant_en;
  logic [2:0] grant_idx;
  logic [7:0] grant;
  logic       timeout;
  logic       busy;

  int checks = 0;
  int errors = 0;

  rr_line_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk        (clk),
    .reset      (r_rst),
    .req        (r_req),
    .release_req(r_rel),
    .grant_en   (grant_en),
    .grant_idx  (grant_idx),
    .grant      (grant),
    .timeout    (timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference: who owns the resource, how long, and where the search starts next.
  int m_owner = -1;
  int m_last  = 0;
  int m_next  = 0;
  int m_held  = 0;
  bit m_cool  = 1'b0;
  bit m_to    = 1'b0;

  task automatic model_step();
    m_to = 1'b0;
    if (r_rst) begin
      m_owner = -1; m_last = 0; m_next = 0; m_held = 0; m_cool = 1'b0;
    end else if (m_owner >= 0) begin
      if (r_rel || !r_req[m_owner] || (MAXH != 0 && m_held == MAXH)) begin
        m_to    = !(r_rel || !r_req[m_owner]);
        m_next  = (m_owner + 1) % 8;
        m_owner = -1;
        m_cool  = 1'b1;
      end else if (m_held < 255) begin
        m_held = m_held + 1;
      end
    end else if (m_cool) begin
      m_cool = 1'b0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (m_owner < 0 && r_req[(m_next + k) % 8]) begin
          m_owner = (m_next + k) % 8;
          m_last  = m_owner;
          m_held  = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] exp_g;
    exp_g = (m_owner >= 0) ? (32'd1 << m_last) : 32'd0;
    chk({tag, "_en"},    32'(grant_en),  32'(m_owner >= 0));
    chk({tag, "_idx"},   32'(grant_idx), 32'(m_last));
    chk({tag, "_grant"}, 32'(grant),     exp_g);
    chk({tag, "_to"},    32'(timeout),   32'(m_to));
    chk({tag, "_busy"},  32'(busy),      32'((m_owner >= 0) || m_cool));
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       rel;
    logic       en;
    logic [2:0] idx;
    logic [7:0] gnt;
    logic       to;
    logic       bsy;
  } vec_t;

  vec_t vecs [28];
  int   gap;

  initial begin
    // Reset, single request on 5, timeout on 3, release at the limit, withdrawal, reset mid-grant.
    vecs[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h20, 1'b0, 1'b1, 3'd5, 8'h20, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 8'h20, 1'b0, 1'b1, 3'd5, 8'h20, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 8'h20, 1'b0, 1'b1, 3'd5, 8'h20, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 8'h20, 1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 8'h08, 1'b0, 1'b0, 3'd3, 8'h00, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 8'h08, 1'b0, 1'b0, 3'd3, 8'h00, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 8'h08, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 8'h08, 1'b0, 1'b0, 3'd3, 8'h00, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd3, 8'h00, 1'b0, 1'b1};
    vecs[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd3, 8'h00, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 8'h04, 1'b0, 1'b1, 3'd2, 8'h04, 1'b0, 1'b1};
    vecs[23] = '{1'b0, 8'h04, 1'b0, 1'b1, 3'd2, 8'h04, 1'b0, 1'b1};
    vecs[24] = '{1'b1, 8'h04, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
    vecs[25] = '{1'b0, 8'h06, 1'b0, 1'b1, 3'd1, 8'h02, 1'b0, 1'b1};
    vecs[26] = '{1'b0, 8'h06, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0, 1'b1};
    vecs[27] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 8'h00, 1'b0, 1'b0};

    #2;
    for (int v = 0; v < 28; v++) begin
      r_rst = vecs[v].rst;
      r_req = vecs[v].req;
      r_rel = vecs[v].rel;
      tick();
      chk($sformatf("vec%0d_en", v),    32'(grant_en),  32'(vecs[v].en));
      chk($sformatf("vec%0d_idx", v),   32'(grant_idx), 32'(vecs[v].idx));
      chk($sformatf("vec%0d_grant", v), 32'(grant),     32'(vecs[v].gnt));
      chk($sformatf("vec%0d_to", v),    32'(timeout),   32'(vecs[v].to));
      chk($sformatf("vec%0d_busy", v),  32'(busy),      32'(vecs[v].bsy));
    end

    // Round-robin over all requesters with a one-cycle release after each grant.
    r_rst = 1'b1; r_req = 8'h00; r_rel = 1'b0;
    tick();
    r_rst = 1'b0; r_req = 8'hFF;
    for (int n = 0; n < 9; n++) begin
      gap = 0;
      if (n > 0) begin
        r_rel = 1'b1;
        tick();
        r_rel = 1'b0;
        gap = 1;
      end
      tick();
      while (!grant_en && gap < 10) begin
        gap++;
        tick();
      end
      chk($sformatf("rr_order%0d", n), 32'(grant_idx), 32'(n % 8));
      chk($sformatf("rr_en%0d", n), 32'(grant_en), 32'd1);
      if (n > 0) chk($sformatf("rr_gap%0d", n), 32'(gap), 32'd2);
      check_model("rr");
    end

    // Pointer rotation: after owner 6 releases, search begins at 7 then wraps.
    r_rst = 1'b1; r_req = 8'h00; r_rel = 1'b0;
    tick();
    r_rst = 1'b0; r_req = 8'h40;
    tick();
    chk("prio_own6", 32'(grant_idx), 32'd6);
    r_rel = 1'b1;
    tick();
    r_rel = 1'b0; r_req = 8'h45;
    tick();
    tick();
    chk("prio_first_en", 32'(grant_en), 32'd1);
    chk("prio_first", 32'(grant_idx), 32'd0);
    r_rel = 1'b1;
    tick();
    r_rel = 1'b0;
    tick();
    tick();
    chk("prio_second_en", 32'(grant_en), 32'd1);
    chk("prio_second", 32'(grant_idx), 32'd2);
    check_model("prio");

    // Random traffic against the model, with occasional resets.
    r_rst = 1'b1; r_rel = 1'b0;
    tick();
    r_rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      r_rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) r_req = 8'($urandom) & 8'($urandom);
        else r_req = 8'($urandom);
      end
      r_rel = ($urandom_range(0, 6) == 0);
      tick();
      check_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
